// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_ADD   = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;

  // Ceiling log2, used to size the iteration counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux3.sv
// Three-input mux; select 2'b11 aliases to d2.
module mux3 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  // Pick one of the three data inputs.
  always_comb begin
    y = d0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      default: y = d2;
    endcase
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Unsigned WIDTH x WIDTH sequential shift-add multiplier, one iteration per clock.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   a_q;
  logic [CW-1:0]      count_q;
  // Chain layout: {carry, acc_hi, Q}
  logic [2*WIDTH:0]   chain_q;
  logic [2*WIDTH:0]   chain_nxt;
  logic [2*WIDTH:0]   add_shift;
  logic [2*WIDTH:0]   shift_only;
  logic [WIDTH:0]     sum;
  logic               load;

  assign load = (state_q == IDLE) && start;

  // Add A into acc_hi at full WIDTH+1 width, then shift the whole chain right;
  // the sum's carry lands in acc_hi's MSB and a zero enters the carry slot.
  always_comb begin
    sum        = {1'b0, chain_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    add_shift  = {1'b0, sum, chain_q[WIDTH-1:1]};
    shift_only = {1'b0, chain_q[2*WIDTH:1]};
  end

  mux3 #(.WIDTH(2*WIDTH+1)) u_mux (
    .sel (sel),
    .d0  (chain_q),
    .d1  (add_shift),
    .d2  (shift_only),
    .y   (chain_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, mux select and handshake outputs.
  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        sel  = chain_q[0] ? SEL_ADD : SEL_SHIFT;
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration chain, counter and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      chain_q <= '0;
      count_q <= '0;
      product <= '0;
    end else begin
      if (load) begin
        a_q     <= multiplicand;
        chain_q <= {1'b0, {WIDTH{1'b0}}, multiplier};
        count_q <= '0;
      end else begin
        chain_q <= chain_nxt;
      end
      if (state_q == RUN) begin
        count_q <= count_q + 1'b1;
        if (count_q == LAST) product <= chain_nxt[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed self-checking bench for seq_shift_add_mult (WIDTH=8).
module tb_seq_shift_add_mult;
  import mult_pkg::*;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait for done, sampling 1 time unit after each rising edge; bounded.
  task automatic wait_done(input string name, output int at);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    check({name, "_done_seen"}, done, 1'b1);
    at = cyc;
  endtask

  // One full operation with latency, busy-length and select-usage checks.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp);
    int n, busy_n, adds;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0; multiplicand = ~a; multiplier = ~b;
    check({name, "_busy_after_start"}, busy, 1'b1);
    n = 0; busy_n = 1; adds = (dut.sel == SEL_ADD) ? 1 : 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
      if (busy && dut.sel == SEL_ADD) adds++;
    end while (!done && n < 40);
    check({name, "_latency"}, n, W);
    check({name, "_busy_cycles"}, busy_n, W);
    check({name, "_busy_in_done"}, busy, 1'b0);
    check({name, "_product"}, product, exp);
    check({name, "_add_iters"}, adds, $countones(b));
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, done, 1'b0);
    check({name, "_product_held"}, product, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, pulses;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   p: 16'h000F};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'h0000};
    vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'h0000};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'h0001};
    vecs[5] = '{a: 8'd255, b: 8'd1,   p: 16'h00FF};
    vecs[6] = '{a: 8'd128, b: 8'd2,   p: 16'h0100};

    // Reset state
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd7; multiplier = 8'd9;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; multiplicand = 8'd1; multiplier = 8'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check("busy_start_product", product, 16'h003F);
      end
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_idle", busy, 1'b0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_product", product, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    do_op("after_rst", 8'd12, 8'd12, 16'h0090);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd2; multiplier = 8'd3;
    wait_done("b2b_first", t1);
    check("b2b_first_product", product, 16'h0006);
    @(negedge clk);
    multiplicand = 8'd4; multiplier = 8'd6;
    wait_done("b2b_second", t2);
    check("b2b_interval", t2 - t1, 10);
    check("b2b_second_product", product, 16'h0018);
    @(negedge clk); start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("b2b_final_idle", busy, 1'b0);
    check("b2b_final_product", product, 16'h0018);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Unsigned WIDTH x WIDTH sequential shift-add multiplier.
- Produces one product bit-slice per clock.
- Sits directly upstream of the product consumer.
- Drives a mux3 instance that selects the accumulator next value: hold, add-and-shift, or shift-only.
- FSM plus iteration counter generate the mux select; start/done handshake to the host.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A; captured on the accepted start edge.
- multiplier  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  result register; holds until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal A, acc_hi, Q, carry and count all cleared.
  - Takes effect immediately, including mid-RUN; no partial result survives.
- State encoding: IDLE, RUN, DONE (shared enum).
- IDLE:
  - Holds product.
  - If start=1 at a rising edge: A<=multiplicand, Q<=multiplier, acc_hi<=0, carry<=0, count<=0, state<=RUN.
  - Otherwise remains in IDLE.
- RUN (busy=1), one iteration per clock:
  - sel=01 when Q[0]=1: {carry,acc_hi}<=acc_hi+A as a WIDTH+1-bit sum, then the {carry,acc_hi,Q} chain is shifted right by 1.
  - sel=10 when Q[0]=0: shift right only, with carry=0 shifted in.
  - The shift and add happen in the same edge via the mux3 data inputs.
  - count increments each iteration. When count==WIDTH-1, this edge is the last iteration: state<=DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - product is loaded on the edge entering DONE with {acc_hi,Q}.
  - Next edge: state<=IDLE.
- Mux select: sel=00 (hold) in IDLE and DONE; sel=11 never generated (mux3 treats it as d2).
- Latency: start accepted at edge 0, RUN iterations occur at edges 1..WIDTH, done is high in the cycle after edge WIDTH. Total start-to-done = WIDTH+1 edges (9 for WIDTH=8).
- start while busy or in DONE: ignored; operands are not recaptured.
- Back-to-back operation: start held high through DONE is accepted at the first IDLE edge. Minimum issue interval = WIDTH+2 cycles.
- Arithmetic width rules:
  - Addition is WIDTH+1 bits; carry never lost.
  - Product is exact; no overflow possible (max (2^W-1)^2 < 2^(2W)).
- Operand changes outside the accepted start edge have no effect.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, RUN, DONE}.
  - mux-select constants SEL_HOLD=2'b00, SEL_ADD=2'b01, SEL_SHIFT=2'b10.
  - count width function clog2(WIDTH).
- Sub-module: the existing mux3, parameterised WIDTH=2*WIDTH+1, selects the {carry,acc_hi,Q} next value.
  - d0=current value.
  - d1=add-then-shift value.
  - d2=shift-only value.
- FSM, counter and operand/product registers live in this module.

Test Plan:
- Basic product: rst_n pulse low then high, start=1 for one cycle, A=3, B=5 -> busy high for 8 cycles, done pulses 9 edges after start, product=16'h000F, busy=0 in the done cycle.
- Maximum operands: A=255, B=255 -> product=16'hFE01 at done; carry path exercised.
- Zero operands: A=0, B=200 -> product=0. A=200, B=0 -> product=0 with all-shift selects (sel never 01).
- Start while busy: A=7, B=9 accepted; mid-RUN, assert start with A=1, B=1 -> ignored, product=16'h003F, exactly one done pulse.
- Reset mid-operation: start A=100, B=100; drop rst_n at iteration 4 -> busy=0, done=0, product=0 immediately (asynchronous). After release, start A=12, B=12 -> product=16'h0090.
- Back-to-back: start held high continuously with A=2, B=3, then A=4, B=6 applied after the first done -> done pulses 10 cycles apart, products 16'h0006 then 16'h0018.
